nr4sdp_seq_multiplier: RTL
==========================

# nr4sdp_seq_multiplier

Sequential signed N×N multiplier controller built around the NR4SD+ recoding scheme. It latches a recoded operand `a` and multiplier `b`, then walks the radix-4 digits of `a` one per clock. Each clock it forms one partial product and accumulates it into a 2N-bit product register. It replaces the fully parallel encoder, partial-product and COR array where area matters more than latency, and produces the same 2N-bit two's-complement product.

## Interface
- `N`, default 8: operand width; must be even and ≥ 4; digit count D = N/2.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  request; sampled only in IDLE.
- `a`  in  N  two's-complement operand to be recoded; sampled with accepted `start`.
- `b`  in  N  two's-complement multiplier; sampled with accepted `start`.
- `busy`  out  1  high while digits are being processed.
- `done`  out  1  one-cycle pulse, high when `product` first becomes valid.
- `product`  out  2N  signed result a·b; held until the next accepted `start`.

## Operation
- Reset (async, `rst_n`=0): state IDLE, `busy`=0, `done`=0, `product`=0, digit counter=0, carry=0.
- States:
  - IDLE: `start`=1 → latch a, b; acc←0, carry←0, cnt←0; go to RUN.
  - RUN: add pp(cnt) into acc; cnt←cnt+1.
    - Once cnt=D−1 has been processed: `product`←final acc, `done`←1, go to IDLE.
- Recoding, digits j=0..D−2 (NR4SD+, digit ∈ {−1,0,+1,+2}):
  - v = 2·a[2j+1] + a[2j] + c_j, with c_0 = 0.
  - v=3 → y=−1, carry 1.
  - v=4 → y=0, carry 1.
  - Otherwise y=v, carry 0.
- Top digit j=D−1 (MB, y ∈ {−2..+2}): y = −2·a[N−1] + a[N−2] + c_{D−1}.
- Partial product: pp(j) = y_j · sext(b), sign-extended to 2N bits, shifted left 2j.
  - acc ← acc + pp(j), mod 2^2N.
  - No separate correction constant is needed because sign extension is full.
- Result is exact: product = a·b as a signed 2N-bit value for all operand pairs, including a = b = −2^(N−1).
- `start` while RUN: ignored; no queuing, no restart.
- `a` and `b` may change freely after the accept edge.

## Timing
- Accept edge E0: `start`=1 in IDLE. `busy`=1 from E0.
- Edges E1..ED process digits 0..D−1. For N=8 that is 4 edges.
- After ED: `busy`=0, `done`=1 for exactly one cycle, and `product` is valid and stable.
- Latency from accept to `done` is D cycles, fixed, independent of digit values. Zero digits are not skipped.
- Back-to-back operation: `start` held high during the `done` cycle is accepted at the next edge, giving throughput of one product per D+1 cycles.
- `product` updates only at ED. It does not change during RUN and keeps the old value until the next result.
- `rst_n` low mid-RUN aborts immediately. All outputs return to reset values, and `done` never pulses for the aborted operation.
- First edge after `rst_n` deasserts: IDLE, `start` honoured normally.

## Structure
- Shared include `nr4sdp_defs.vh` holds:
  - state encodings (IDLE, RUN);
  - digit-control field layout `{one_p, one_m, two_p}` for low digits and `{sign, one, two}` for the top digit;
  - localparam D = N/2.
- Sub-module `nr4sdp_digit_unit` is combinational. It maps (pair bits, carry_in, is_top) → (digit controls, carry_out) and, together with `b`, produces the 2N-bit pp.
- The top module holds the FSM, counter, carry register, operand registers, accumulator and output register.
- The counter is ⌈log2 D⌉ bits wide. The carry register is 1 bit.

## Test plan
- a=0x5C (92), b=0x7B (123), start at E0:
  - digits 0, −1, +2, +1;
  - `busy` high for 4 cycles, then `done`=1 and `product`=0x2C34 (11316).
- a=0x80, b=0x80 → 0x4000. a=0x80, b=0x7F → 0xC080 (−16256). Checks top digit −2 and extremes.
- a=0xFF, b=0x05:
  - carries chain through all digits (−1, 0, 0, 0);
  - `product`=0xFFFB.
- `start` pulsed at E2 during RUN: ignored; the result of the first operation is unchanged and appears at E4. Then `start` held high through `done`: second operation accepted at the next edge, `done` again 4 cycles later.
- `rst_n` asserted at E2 mid-operation: `busy`, `done` and `product` go to 0 immediately. No `done` pulse follows, and a fresh start after release gives the correct product.
- Randomised sweep, all 65536 (a, b) pairs for N=8: `product` equals the signed a·b every time and `done` always arrives exactly 4 cycles after accept.

Source files
------------

// File: rtl/nr4sdp_seq_multiplier_pkg.sv
// nr4sdp_seq_multiplier_pkg: shared states, digit-control layouts and sizing helpers
package nr4sdp_seq_multiplier_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Low digits take values in {-1, 0, +1, +2}.
    typedef struct packed {
        logic one_p;
        logic one_m;
        logic two_p;
    } low_ctrl_t;

    // The top digit is a plain Booth digit in {-2..+2}.
    typedef struct packed {
        logic sign;
        logic one;
        logic two;
    } top_ctrl_t;

    function automatic int digit_count(input int n);
        return n / 2;
    endfunction

    function automatic int cnt_width(input int d);
        return (d > 1) ? $clog2(d) : 1;
    endfunction

endpackage

// File: rtl/nr4sdp_digit_unit.sv
// nr4sdp_digit_unit: recodes one radix-4 digit of a and forms its unshifted 2N-bit partial product
module nr4sdp_digit_unit
    import nr4sdp_seq_multiplier_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [1:0]     pair,
    input  logic           carry_in,
    input  logic           is_top,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] pp,
    output logic           carry_out
);

    logic [2:0]     v;
    logic [1:0]     t;
    low_ctrl_t      lc;
    top_ctrl_t      tc;
    logic [2*N-1:0] bx;
    logic [2*N-1:0] mag;
    logic [2*N-1:0] low_pp;
    logic [2*N-1:0] top_pp;

    // Decode digit controls and select the matching multiple of sign-extended b.
    always_comb begin
        v         = {1'b0, pair} + {2'b0, carry_in};
        t         = {1'b0, pair[0]} + {1'b0, carry_in};
        lc.one_p  = v == 3'd1;
        lc.one_m  = v == 3'd3;
        lc.two_p  = v == 3'd2;
        tc.sign   = pair[1] & (t != 2'd2);
        tc.one    = t == 2'd1;
        tc.two    = pair[1] ? (t == 2'd0) : (t == 2'd2);
        carry_out = !is_top && (v[2] || v == 3'd3);
        bx        = {{N{b[N-1]}}, b};
        low_pp    = lc.one_p ? bx : lc.one_m ? -bx : lc.two_p ? bx << 1 : '0;
        mag       = tc.one ? bx : tc.two ? bx << 1 : '0;
        top_pp    = tc.sign ? -mag : mag;
        pp        = is_top ? top_pp : low_pp;
    end

endmodule

// File: rtl/nr4sdp_seq_multiplier.sv
// nr4sdp_seq_multiplier: sequential signed NxN multiplier, one NR4SD+ digit per clock
module nr4sdp_seq_multiplier
    import nr4sdp_seq_multiplier_pkg::*;
#(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int D  = digit_count(N);
    localparam int CW = cnt_width(D);

    state_t         state;
    logic [N-1:0]   a_r;
    logic [N-1:0]   b_r;
    logic [2*N-1:0] acc;
    logic [2*N-1:0] pp;
    logic [2*N-1:0] sum;
    logic [CW-1:0]  cnt;
    logic           carry;
    logic           carry_next;
    logic           last;

    assign last = cnt == CW'(D - 1);
    assign sum  = acc + (pp << {cnt, 1'b0});

    nr4sdp_digit_unit #(.N(N)) u_digit (
        .pair      (a_r[{cnt, 1'b0} +: 2]),
        .carry_in  (carry),
        .is_top    (last),
        .b         (b_r),
        .pp        (pp),
        .carry_out (carry_next)
    );

    // Control FSM: accept in IDLE, accumulate one digit per RUN cycle, publish on the last digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_r     <= '0;
            b_r     <= '0;
            acc     <= '0;
            cnt     <= '0;
            carry   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_r   <= a;
                        b_r   <= b;
                        acc   <= '0;
                        cnt   <= '0;
                        carry <= 1'b0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc   <= sum;
                    carry <= carry_next;
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        product <= sum;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
